// File: rtl/mil_tx_fifo.sv
// MIL-STD-1553 style Manchester transmitter with a word FIFO in front.
// Each word is sync (3 bit times), 16 data bits MSB first, then one parity bit.
// Line outputs lag the state machine by one clock because they are registered.
module mil_tx_fifo #(
  parameter int FCLK     = 50000000,
  parameter int TXVEL    = 1000000,
  parameter int DEPTH    = 8,
  parameter int PAR_ODD  = 1,
  parameter int GAP_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [15:0]              wr_dat,
  input  logic                     wr_cw,
  input  logic                     tx_en,
  input  logic                     clr_ovf,
  output logic                     TXP,
  output logic                     TXN,
  output logic                     busy,
  output logic                     word_done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int HALF   = FCLK / (2 * TXVEL);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = $clog2(HALF);
  localparam int GAP_HB = 2 * GAP_BITS;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_t;

  state_t          state, state_n;
  logic [16:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [16:0]     head;
  logic            push, pop;
  logic [PW-1:0]   presc;
  logic            half_end;
  logic [5:0]      hb;
  logic            cw_q, par_q;
  logic [15:0]     dat_q;
  logic            line_act, line_p;
  logic [4:0]      dh;

  assign full     = (level == (AW + 1)'(DEPTH));
  assign empty    = (level == '0);
  // A write into a full FIFO is still taken when a pop frees a slot that cycle.
  assign push     = wr_en && (!full || pop);
  assign head     = mem[rd_ptr];
  assign half_end = (presc == PW'(HALF - 1));
  assign busy     = (state != S_IDLE);

  // FIFO storage; contents need no reset because the pointers define validity.
  // NOTE: memories are left unreset so they map onto RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_cw, wr_dat};
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end

  // Sticky overflow; setting wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                              ovf <= 1'b0;
    else if (wr_en && full && !pop)       ovf <= 1'b1;
    else if (clr_ovf)                     ovf <= 1'b0;
  end

  // Word sequencer: next state and pop decision at word boundaries.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: if (tx_en && !empty) begin
        state_n = S_SYNC;
        pop     = 1'b1;
      end
      S_SYNC: if (half_end && hb == 6'd5)  state_n = S_DATA;
      S_DATA: if (half_end && hb == 6'd37) state_n = S_PAR;
      S_PAR: if (half_end && hb == 6'd39) begin
        if (tx_en && !empty) begin
          state_n = S_SYNC;
          pop     = 1'b1;
        end else begin
          state_n = S_GAP;
        end
      end
      S_GAP: if (half_end && hb == 6'(GAP_HB - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Half-bit prescaler: held at zero in IDLE, free-running otherwise.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) presc <= '0;
    else if (half_end)          presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  // Half-bit index: 0..39 across a word, 0..GAP_HB-1 across the gap.
  always_ff @(posedge clk) begin
    if (rst)                hb <= '0;
    else if (pop)           hb <= '0;
    else if (half_end)      hb <= ((state_n != state) &&
                                   (state_n == S_GAP || state_n == S_IDLE)) ? '0 : hb + 6'd1;
  end

  // Latch the popped word and its parity for the duration of transmission.
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q  <= 1'b0;
      dat_q <= '0;
      par_q <= 1'b0;
    end else if (pop) begin
      cw_q  <= head[16];
      dat_q <= head[15:0];
      par_q <= (PAR_ODD != 0) ? ~^head[15:0] : ^head[15:0];
    end
  end

  // Manchester encoding of the current half-bit; line_p is the TXP level.
  always_comb begin
    line_act = 1'b0;
    line_p   = 1'b0;
    dh       = 5'(hb - 6'd6);
    case (state)
      S_SYNC: begin
        line_act = 1'b1;
        line_p   = (hb < 6'd3) ? cw_q : ~cw_q;
      end
      S_DATA: begin
        line_act = 1'b1;
        line_p   = dat_q[4'd15 - dh[4:1]] ^ dh[0];
      end
      S_PAR: begin
        line_act = 1'b1;
        line_p   = par_q ^ hb[0];
      end
      default: ;
    endcase
  end

  // Registered line drivers and end-of-word strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      TXP       <= 1'b0;
      TXN       <= 1'b0;
      word_done <= 1'b0;
    end else begin
      TXP       <= line_act & line_p;
      TXN       <= line_act & ~line_p;
      word_done <= (state == S_PAR) && (hb == 6'd39) && half_end;
    end
  end

endmodule
